change_monitor_mc: RTL and testbench

//  Multi-channel input-change monitor, next generation of the two-byte change detector.

---
 rtl/change_monitor_mc_if.sv | 29 ++
 rtl/change_monitor_mc.sv | 77 +++++++
 tb/tb_change_monitor_mc.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/change_monitor_mc_if.sv
// change_monitor_mc_if: channel data, event drain port and status of the change monitor.
interface change_monitor_mc_if #(
   parameter int W     = 8,
   parameter int N     = 2,
   parameter int CNT_W = 8
);
   localparam int CH_W = N > 1 ? $clog2(N) : 1;
   logic [N*W-1:0]   din;
   logic             mode;
   logic [N*W-1:0]   q;
   logic [N*W-1:0]   acc;
   logic [N-1:0]     changed;
   logic             any_chg;
   logic             evt_valid;
   logic             evt_ready;
   logic [CH_W-1:0]  evt_chan;
   logic [W-1:0]     evt_data;
   logic [N-1:0]     overrun;
   logic             clr_ovr;
   logic [CNT_W-1:0] evt_cnt;
   modport master (
      output din, mode, evt_ready, clr_ovr,
      input  q, acc, changed, any_chg, evt_valid, evt_chan, evt_data, overrun, evt_cnt
   );
   modport slave (
      input  din, mode, evt_ready, clr_ovr,
      output q, acc, changed, any_chg, evt_valid, evt_chan, evt_data, overrun, evt_cnt
   );
endinterface

// File: rtl/change_monitor_mc.sv
// change_monitor_mc: multi-channel change monitor with optional debounce and a
// lowest-index-first event queue drained over a valid/ready port.
module change_monitor_mc #(
   parameter int W      = 8,
   parameter int N      = 2,
   parameter int STABLE = 4,
   parameter int CNT_W  = 8
) (
   input logic                clk,
   input logic                rst,
   change_monitor_mc_if.slave bus
);
   localparam int CH_W = N > 1 ? $clog2(N) : 1;
   localparam int HC_W = STABLE > 1 ? $clog2(STABLE + 1) : 1;

   logic [N-1:0][W-1:0]    r_prev;
   logic [N-1:0][W-1:0]    r_acc;
   logic [N-1:0][HC_W-1:0] r_cnt;
   logic [N-1:0]           r_pend;
   logic [N-1:0]           r_ovr;
   logic [CNT_W-1:0]       r_evt_cnt;
   logic [N-1:0]           w_changed;
   logic [N-1:0]           w_accept;
   logic [N-1:0]           w_hold;
   logic [N-1:0]           w_xfer_vec;
   logic [CH_W-1:0]        w_chan;
   logic                   w_xfer;

   always_comb begin
      w_changed = '0;
      w_accept  = '0;
      w_hold    = '0;
      w_chan    = '0;
      for (int i = 0; i < N; i++) begin
         w_changed[i] = bus.din[i*W +: W] != r_prev[i];
         w_accept[i]  = !w_changed[i] && r_prev[i] != r_acc[i] &&
                        (!bus.mode || r_cnt[i] == HC_W'(STABLE - 1));
         w_hold[i]    = bus.mode && !w_changed[i] && r_prev[i] != r_acc[i] && !w_accept[i];
      end
      // descending scan leaves the lowest pending index selected
      for (int i = N - 1; i >= 0; i--)
         if (r_pend[i]) w_chan = CH_W'(i);
   end

   assign w_xfer     = |r_pend && bus.evt_ready;
   assign w_xfer_vec = w_xfer ? N'(1) << w_chan : '0;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_prev    <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_pend    <= '0;
         r_ovr     <= '0;
         r_evt_cnt <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            r_prev[i] <= bus.din[i*W +: W];
            if (w_accept[i]) r_acc[i] <= r_prev[i];
            r_cnt[i] <= w_hold[i] ? r_cnt[i] + 1'b1 : '0;
         end
         // a re-accept on the transfer edge refills the slot without losing data
         r_pend <= (r_pend & ~w_xfer_vec) | w_accept;
         r_ovr  <= (bus.clr_ovr ? '0 : r_ovr) | (w_accept & r_pend & ~w_xfer_vec);
         if (w_xfer && r_evt_cnt != '1) r_evt_cnt <= r_evt_cnt + 1'b1;
      end

   assign bus.q         = r_prev;
   assign bus.acc       = r_acc;
   assign bus.changed   = w_changed;
   assign bus.any_chg   = |w_changed;
   assign bus.evt_valid = |r_pend;
   assign bus.evt_chan  = w_chan;
   assign bus.evt_data  = r_acc[w_chan];
   assign bus.overrun   = r_ovr;
   assign bus.evt_cnt   = r_evt_cnt;
endmodule

// File: tb/tb_change_monitor_mc.sv
// tb_change_monitor_mc: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of the accept, event-queue and counter rules.
module tb_change_monitor_mc;
   localparam int W = 8, N = 2, STABLE = 4, CNT_W = 8;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [W-1:0] m_prev [N];
   logic [W-1:0] m_acc [N];
   int           m_run [N];
   logic [N-1:0] m_pend, m_ovr;
   int           m_cnt;

   change_monitor_mc_if #(.W(W), .N(N), .CNT_W(CNT_W)) bus ();
   change_monitor_mc #(.W(W), .N(N), .STABLE(STABLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int c = 0; c < N; c++) begin
         m_prev[c] = '0;
         m_acc[c]  = '0;
         m_run[c]  = 0;
      end
      m_pend = '0;
      m_ovr  = '0;
      m_cnt  = 0;
   endtask

   function automatic int first_pend();
      for (int c = 0; c < N; c++) if (m_pend[c]) return c;
      return 0;
   endfunction

   // m_run: consecutive edges a differing value has waited unaccepted in debounce mode
   task automatic model_edge();
      logic [N-1:0] take, xv;
      logic [W-1:0] d;
      logic xfer;
      int xc;
      xfer = (m_pend != 0) && bus.evt_ready;
      xc   = first_pend();
      xv   = xfer ? N'(1) << xc : '0;
      for (int c = 0; c < N; c++) begin
         d = bus.din[c*W +: W];
         take[c] = d == m_prev[c] && m_prev[c] != m_acc[c] && (!bus.mode || m_run[c] >= STABLE - 1);
         m_run[c] = (d != m_prev[c] || m_prev[c] == m_acc[c] || take[c]) ? 0 : m_run[c] + 1;
      end
      if (xfer && m_cnt < 255) m_cnt++;
      if (bus.clr_ovr) m_ovr = '0;
      m_ovr  = m_ovr | (take & m_pend & ~xv);
      m_pend = (m_pend & ~xv) | take;
      for (int c = 0; c < N; c++) begin
         if (take[c]) m_acc[c] = m_prev[c];
         m_prev[c] = bus.din[c*W +: W];
      end
   endtask

   task automatic check_all();
      logic [N-1:0]   ch;
      logic [N*W-1:0] eq, ea;
      int ec;
      for (int c = 0; c < N; c++) begin
         ch[c] = bus.din[c*W +: W] != m_prev[c];
         eq[c*W +: W] = m_prev[c];
         ea[c*W +: W] = m_acc[c];
      end
      ec = first_pend();
      chk("q", bus.q, eq);
      chk("acc", bus.acc, ea);
      chk("changed", bus.changed, ch);
      chk("any_chg", bus.any_chg, |ch);
      chk("evt_valid", bus.evt_valid, m_pend != 0);
      chk("overrun", bus.overrun, m_ovr);
      chk("evt_cnt", bus.evt_cnt, m_cnt);
      if (m_pend != 0) begin
         chk("evt_chan", bus.evt_chan, ec);
         chk("evt_data", bus.evt_data, m_acc[ec]);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (rst) model_edge();
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic set_ch(input int c, input logic [W-1:0] v);
      bus.din[c*W +: W] = v;
   endtask

   initial begin
      bus.din = '0;
      bus.mode = 1'b0;
      bus.evt_ready = 1'b0;
      bus.clr_ovr = 1'b0;
      m_reset();
      #2 check_all();
      chk("rst_valid", bus.evt_valid, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      // immediate accept, single event drained
      steps(2);
      set_ch(0, 8'h5A);
      #1 chk("t1_changed", bus.changed[0], 1);
      steps(2);
      chk("t1_acc0", bus.acc[7:0], 8'h5A);
      chk("t1_valid", bus.evt_valid, 1);
      chk("t1_chan", bus.evt_chan, 0);
      chk("t1_data", bus.evt_data, 8'h5A);
      bus.evt_ready = 1'b1;
      step();
      bus.evt_ready = 1'b0;
      chk("t1_cnt", bus.evt_cnt, 1);
      // debounce: short pulse rejected, held value accepted after STABLE edges
      bus.mode = 1'b1;
      set_ch(1, 8'h33);
      steps(2);
      set_ch(1, 8'h00);
      steps(6);
      chk("t2_glitch_valid", bus.evt_valid, 0);
      chk("t2_glitch_acc1", bus.acc[15:8], 0);
      set_ch(1, 8'h33);
      steps(4);
      chk("t2_acc1_early", bus.acc[15:8], 0);
      step();
      chk("t2_acc1", bus.acc[15:8], 8'h33);
      chk("t2_chan", bus.evt_chan, 1);
      bus.evt_ready = 1'b1;
      step();
      bus.evt_ready = 1'b0;
      // both channels accept together, drained lowest first
      bus.mode = 1'b0;
      bus.evt_ready = 1'b1;
      bus.din = {8'h44, 8'h44};
      steps(2);
      chk("t3_chan0", bus.evt_chan, 0);
      step();
      chk("t3_valid1", bus.evt_valid, 1);
      chk("t3_chan1", bus.evt_chan, 1);
      step();
      chk("t3_empty", bus.evt_valid, 0);
      chk("t3_cnt", bus.evt_cnt, 4);
      // overrun set, clear, and set-wins-over-clear
      bus.evt_ready = 1'b0;
      set_ch(0, 8'h11);
      steps(2);
      set_ch(0, 8'h22);
      steps(2);
      chk("t4_ovr", bus.overrun, 2'b01);
      chk("t4_data", bus.evt_data, 8'h22);
      bus.clr_ovr = 1'b1;
      step();
      bus.clr_ovr = 1'b0;
      chk("t4_clr", bus.overrun, 0);
      set_ch(0, 8'h33);
      step();
      bus.clr_ovr = 1'b1;
      step();
      bus.clr_ovr = 1'b0;
      chk("t4_set_wins", bus.overrun, 2'b01);
      bus.clr_ovr = 1'b1;
      step();
      bus.clr_ovr = 1'b0;
      // re-accept on the transfer edge keeps the event without overrun
      set_ch(0, 8'h66);
      step();
      bus.evt_ready = 1'b1;
      step();
      chk("t5_valid", bus.evt_valid, 1);
      chk("t5_ovr", bus.overrun, 0);
      chk("t5_data", bus.evt_data, 8'h66);
      step();
      chk("t5_empty", bus.evt_valid, 0);
      chk("t5_cnt", bus.evt_cnt, 6);
      // counter saturation
      for (int i = 0; i < 260; i++) begin
         set_ch(0, (i % 2 == 1) ? 8'hA1 : 8'hA0);
         steps(2);
      end
      chk("t6_sat", bus.evt_cnt, 8'hFF);
      set_ch(0, 8'hA7);
      steps(3);
      chk("t6_sat_hold", bus.evt_cnt, 8'hFF);
      // asynchronous reset in the middle of a debounce hold
      bus.evt_ready = 1'b0;
      bus.mode = 1'b1;
      set_ch(1, 8'h77);
      steps(2);
      rst = 1'b0;
      #1 m_reset();
      chk("t6_rst_acc", bus.acc, 0);
      chk("t6_rst_q", bus.q, 0);
      chk("t6_rst_valid", bus.evt_valid, 0);
      chk("t6_rst_cnt", bus.evt_cnt, 0);
      chk("t6_rst_ovr", bus.overrun, 0);
      bus.din = '0;
      steps(2);
      rst = 1'b1;
      steps(8);
      chk("t6_no_evt", bus.evt_valid, 0);
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(3) == 0) set_ch(c, 8'($urandom_range(3)));
         if ($urandom_range(20) == 0) bus.mode = ~bus.mode;
         bus.evt_ready = 1'($urandom_range(1));
         bus.clr_ovr = $urandom_range(15) == 0;
         if ($urandom_range(400) == 0) begin
            rst = 1'b0;
            #1 m_reset();
         end else rst = 1'b1;
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
